serial_adder: RTL and testbench

- Bit-serial N-bit adder built around a single full-adder cell plus a registered carry.
- Operands are loaded on a start pulse and shifted LSB-first through the cell, one bit per clock.
- Sum bits are collected into a result shift register; a one-cycle done pulse marks a valid result.
- Sits directly downstream of the full-adder cell: it is the sequential datapath that consumes the cell's sum/carry outputs each cycle.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/bit_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one so WIDTH=1 still has a counter.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_fa_cell.sv
// Single combinational full-adder cell, reused every cycle by serial_adder.
module bit_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full-adder
// cell with a registered carry; result lands in sum/cout with a done pulse.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sr_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;
  logic             last;

  bit_fa_cell u_fa (
    .x  (a_reg[0]),
    .y  (b_reg[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  // Written as a shift/or so WIDTH=1 needs no special slicing.
  assign sr_next = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign last    = (cnt == CW'(WIDTH - 1));

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Control FSM plus serial datapath; start is honoured only in IDLE and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sum_sr <= sr_next;
          carry  <= co;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum   <= sr_next;
            cout  <= co;
`ifdef SERIAL_ADDER_OVF_EN
            // On the last bit, carry holds the carry into the MSB.
            ovf   <= carry ^ co;
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Expected results come from plain integer addition of the operands.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf1;
  logic       last_ovf = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] last_res = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[8:0];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
    int ia, ib, t;
    ia = int'($signed(x));
    ib = int'($signed(y));
    t  = ia + ib + int'(c);
    return (t > 127) || (t < -128);
  endfunction

  // Stimulus only: present operands with start for one edge, then scramble inputs.
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic c);
    start = 1'b1; a = x; b = y; cin = c;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL reset_sum got %h want 00", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
    n_cmp++; if ({busy1, done1, cout1, sum1} !== 4'b0) begin n_err++; $display("FAIL reset_w1 got %b want 0000", {busy1, done1, cout1, sum1}); end
`ifdef SERIAL_ADDER_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Directed vectors followed by random ones; checks busy window, held result and final value.
  task automatic test_add();
    logic [7:0] va [3] = '{8'h00, 8'hFF, 8'h5A};
    logic [7:0] vb [3] = '{8'h00, 8'h01, 8'h3C};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] x, y;
    logic c;
    logic [8:0] exp;
    for (int k = 0; k < 23; k++) begin
      if (k < 3) begin x = va[k]; y = vb[k]; c = vc[k]; end
      else begin x = 8'($urandom); y = 8'($urandom); c = 1'($urandom); end
      exp = ref_add(x, y, c);
      @(negedge clk);
      launch(x, y, c);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL add_busy op%0d cyc%0d got busy=%b done=%b want 1/0", k, i, busy, done); end
        n_cmp++; if ({cout, sum} !== last_res) begin n_err++; $display("FAIL add_hold op%0d cyc%0d got %h want %h", k, i, {cout, sum}, last_res); end
      end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL add_done op%0d got done=%b busy=%b want 1/0", k, done, busy); end
      n_cmp++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL add_result op%0d %h+%h+%b got %h want %h", k, x, y, c, {cout, sum}, exp); end
`ifdef SERIAL_ADDER_OVF_EN
      n_cmp++; if (ovf !== ref_ovf(x, y, c)) begin n_err++; $display("FAIL add_ovf op%0d got %b want %b", k, ovf, ref_ovf(x, y, c)); end
      last_ovf = ref_ovf(x, y, c);
`endif
      last_res = exp;
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse op%0d got %b want 0", k, done); end
    end
  endtask

  task automatic test_ignore_start();
    logic [8:0] exp;
    exp = ref_add(8'hC3, 8'h2D, 1'b1);
    @(negedge clk);
    launch(8'hC3, 8'h2D, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy cyc%0d got %b want 1", i, busy); end
      if (i == 2) begin start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; end
      if (i == 3) start = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || {cout, sum} !== exp) begin n_err++; $display("FAIL ign_result got done=%b %h want 1 %h", done, {cout, sum}, exp); end
    last_res = exp;
`ifdef SERIAL_ADDER_OVF_EN
    last_ovf = ref_ovf(8'hC3, 8'h2D, 1'b1);
`endif
    @(negedge clk);
  endtask

  // Start is already high during DONE, so each new op begins with no idle cycle.
  task automatic test_back_to_back();
    logic [7:0] x, y;
    logic c;
    logic [8:0] exp;
    x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
    @(negedge clk);
    launch(x, y, c);
    for (int k = 0; k < 4; k++) begin
      exp = ref_add(x, y, c);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy op%0d cyc%0d got %b want 1", k, i, busy); end
      end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1 || {cout, sum} !== exp) begin n_err++; $display("FAIL b2b_result op%0d got done=%b %h want 1 %h", k, done, {cout, sum}, exp); end
      last_res = exp;
`ifdef SERIAL_ADDER_OVF_EN
      last_ovf = ref_ovf(x, y, c);
`endif
      if (k < 3) begin
        x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
        launch(x, y, c);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic seen_done;
    logic [8:0] exp;
    @(negedge clk);
    launch(8'hAB, 8'hCD, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mrst_ctrl got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if ({cout, sum} !== 9'h000) begin n_err++; $display("FAIL mrst_result got %h want 000", {cout, sum}); end
    @(negedge clk); rst_n = 1'b1;
    last_res = '0;
`ifdef SERIAL_ADDER_OVF_EN
    last_ovf = 1'b0;
`endif
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL mrst_quiet got activity=%b want 0", seen_done); end
    exp = ref_add(8'h80, 8'h80, 1'b1);
    launch(8'h80, 8'h80, 1'b1);
    repeat (8) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1 || {cout, sum} !== exp) begin n_err++; $display("FAIL mrst_fresh got done=%b %h want 1 %h", done, {cout, sum}, exp); end
    last_res = exp;
    @(negedge clk);
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start1 = 1'b1; a1 = 1'(k >> 2); b1 = 1'(k >> 1); cin1 = 1'(k);
      exp = 2'(((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1));
      @(posedge clk); #1;
      start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      @(negedge clk);
      n_cmp++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_err++; $display("FAIL w1_busy k%0d got busy=%b done=%b want 1/0", k, busy1, done1); end
      @(negedge clk);
      n_cmp++; if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin n_err++; $display("FAIL w1_result k%0d got done=%b %b want 1 %b", k, done1, {cout1, sum1}, exp); end
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [7:0] va [2] = '{8'h7F, 8'hFF};
    logic       vo [2] = '{1'b1, 1'b0};
    logic [8:0] ve [2] = '{9'h080, 9'h100};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      launch(va[k], 8'h01, 1'b0);
      repeat (8) @(negedge clk);
      @(negedge clk);
      n_cmp++; if (done !== 1'b1 || {cout, sum} !== ve[k] || ovf !== vo[k]) begin n_err++; $display("FAIL ovf_dir k%0d got done=%b %h ovf=%b want 1 %h %b", k, done, {cout, sum}, ovf, ve[k], vo[k]); end
      last_res = ve[k];
      last_ovf = vo[k];
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_width1();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
